dmem_bridge: RTL and testbench
==============================

DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state changes on rising edge.
REQ-002 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: mem_en  in  1  MEM-stage instruction is a load or store.
REQ-004 SHALL have ports: mem_wr  in  1  1 = store, 0 = load.
REQ-005 SHALL have ports: mem_size  in  2  0 = byte, 1 = half, 2 = word.
REQ-006 SHALL have ports: mem_sign  in  1  sign-extend load result.
REQ-007 SHALL have ports: mem_addr  in  32  byte address; mem_wdata  in  32  store data, already lane-aligned.
REQ-008 SHALL have ports: flush  in  1  MEM-stage instruction is cancelled.
REQ-009 SHALL have ports: pipe_hold  in  1  EX/MEM register is held by another stall source.
REQ-010 SHALL have ports: mem_rdata  out  32  extended load result.
REQ-011 SHALL have ports: mem_stall_o  out  1  memory stage busy; data_ok_o  out  1  transaction completion pulse to stall control.
REQ-012 SHALL have ports: data_req  out  1; data_wr  out  1; data_size  out  2; data_addr  out  32; data_wdata  out  32.
REQ-013 SHALL have ports: data_addr_ok  in  1; data_data_ok  in  1; data_rdata  in  32.

Function
REQ-014 SHALL have states IDLE, REQ, WAIT, DONE, and SHALL allow one outstanding bus transaction at most.
REQ-015 IDLE: on mem_en & ~flush, SHALL latch wr/size/sign/addr/wdata and enter REQ next cycle.
REQ-016 REQ: SHALL drive data_req=1 with latched fields, stable until data_addr_ok; on data_addr_ok SHALL enter WAIT.
REQ-017 data_data_ok seen in IDLE, REQ or DONE SHALL be ignored.
REQ-018 WAIT: on data_data_ok SHALL capture the result; if pipe_hold then DONE, else IDLE.
REQ-019 DONE: SHALL hold the result; when pipe_hold=0, SHALL go to IDLE.
REQ-020 mem_stall_o SHALL be 1 when the stage needs to wait: (IDLE & mem_en & ~flush), REQ, or (WAIT & ~data_data_ok); otherwise 0; always 0 while cancel=1.
REQ-021 data_ok_o SHALL pulse 1 for exactly the WAIT cycle in which data_data_ok=1 and cancel=0.
REQ-022 mem_rdata: from data_rdata on the completing cycle, from the held register in DONE; byte/half lane selected by addr[1:0] (half by addr[1]), zero- or sign-extended per mem_sign; word passes through.
REQ-023 Flush in IDLE or DONE SHALL discard the instruction and return to or stay in IDLE.
REQ-024 Flush in REQ or WAIT SHALL set cancel. The request SHALL NOT be withdrawn. The transaction completes on the bus, the result is discarded, and the block returns to IDLE.
REQ-025 Flush in REQ or WAIT SHALL keep mem_stall_o=0 and data_ok_o=0 from the flush cycle on. A new mem_en SHALL NOT be accepted until the cancelled transaction completes.
REQ-026 Minimum load/store latency SHALL be 3 cycles: IDLE accept, REQ with addr_ok, WAIT with data_ok.

Reset
REQ-027 On rst=1 at a clock edge, SHALL enter IDLE, clear cancel and the result register, and drive data_req=0, mem_stall_o=0, data_ok_o=0, mem_rdata=0.
REQ-028 Reset mid-transaction SHALL abandon it; data_data_ok arriving after reset SHALL be ignored.

Verification
REQ-029 Word load, addr 0x100, addr_ok at 1st REQ cycle, data_ok 1 cycle later with rdata 0xDEADBEEF -> mem_stall_o high 2 cycles; mem_rdata=0xDEADBEEF with data_ok_o=1 in 3rd cycle.
REQ-030 Signed byte load, addr 0x103, rdata 0x80xxxxxx -> mem_rdata=0xFFFFFF80; unsigned -> 0x00000080.
REQ-031 Store with addr_ok delayed 4 cycles -> data_req and the latched fields stay constant for all 4 cycles; mem_stall_o stays high until data_ok.
REQ-032 Completion while pipe_hold=1 for 3 cycles -> enter DONE; mem_rdata held; mem_stall_o=0; single data_ok_o pulse; IDLE after pipe_hold falls.
REQ-033 Flush in WAIT -> mem_stall_o=0 immediately; no data_ok_o pulse; next mem_en is accepted only after data_data_ok.
REQ-034 rst asserted in REQ -> next cycle data_req=0, IDLE; a later stray data_data_ok produces no output change.

Source files
------------

// File: rtl/dmem_bridge_if.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_bridge_if
//  Description : Signal bundle between the MEM pipeline stage, the data-memory
//                bridge and the split-handshake data bus.
//                  slave  - the bridge itself
//                  master - the environment (pipeline + memory) around it
//  Signals     : mem_*        pipeline request / result
//                flush        MEM-stage instruction cancelled
//                pipe_hold    EX/MEM register held by another stall source
//                mem_stall_o  memory stage busy
//                data_ok_o    transaction completion pulse
//                data_*       bus request (req/wr/size/addr/wdata) and
//                             response (addr_ok/data_ok/rdata)
//  Revision    : 1.0 - initial release
// ============================================================================
interface dmem_bridge_if;
   // pipeline side
   logic        mem_en;
   logic        mem_wr;
   logic [1:0]  mem_size;
   logic        mem_sign;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        flush;
   logic        pipe_hold;
   logic [31:0] mem_rdata;
   logic        mem_stall_o;
   logic        data_ok_o;
   // bus side
   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic [31:0] data_rdata;

   modport slave (
      input  mem_en, mem_wr, mem_size, mem_sign, mem_addr, mem_wdata,
      input  flush, pipe_hold,
      output mem_rdata, mem_stall_o, data_ok_o,
      output data_req, data_wr, data_size, data_addr, data_wdata,
      input  data_addr_ok, data_data_ok, data_rdata
   );

   modport master (
      output mem_en, mem_wr, mem_size, mem_sign, mem_addr, mem_wdata,
      output flush, pipe_hold,
      input  mem_rdata, mem_stall_o, data_ok_o,
      input  data_req, data_wr, data_size, data_addr, data_wdata,
      output data_addr_ok, data_data_ok, data_rdata
   );
endinterface
`default_nettype wire

// File: rtl/dmem_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_bridge
//  Description : Bridges the MEM pipeline stage to a split address/data
//                handshake bus. One outstanding transaction at most.
//                IDLE -> REQ (data_req until addr_ok) -> WAIT (until data_ok)
//                -> DONE (only while pipe_hold keeps the result alive).
//                A flush while the bus is busy cancels the instruction but
//                lets the bus transaction run to completion.
//  Ports       : clk  - clock, rising edge
//                rst  - synchronous active-high reset
//                bus  - dmem_bridge_if.slave (pipeline + data bus signals)
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_bridge (
   input  wire logic    clk,
   input  wire logic    rst,
   dmem_bridge_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic        wr_q, wr_d;
   logic [1:0]  size_q, size_d;
   logic        sign_q, sign_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] res_q, res_d;
   logic        cancel_q, cancel_d;

   logic        w_busy;      // REQ or WAIT: a bus transaction is in flight
   logic        w_cancel;    // instruction cancelled, effective this cycle
   logic        w_complete;  // bus returns data this cycle
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_ext;

   // ------------------------------------------------------------------------
   // Load-result extraction from the raw bus word, using the latched fields
   // ------------------------------------------------------------------------
   always_comb begin
      w_byte = bus.data_rdata[7:0];
      case (addr_q[1:0])
         2'd0:    w_byte = bus.data_rdata[7:0];
         2'd1:    w_byte = bus.data_rdata[15:8];
         2'd2:    w_byte = bus.data_rdata[23:16];
         default: w_byte = bus.data_rdata[31:24];
      endcase
      w_half = addr_q[1] ? bus.data_rdata[31:16] : bus.data_rdata[15:0];
      case (size_q)
         2'd0:    w_ext = {{24{sign_q & w_byte[7]}}, w_byte};
         2'd1:    w_ext = {{16{sign_q & w_half[15]}}, w_half};
         default: w_ext = bus.data_rdata;
      endcase
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      wr_d    = wr_q;
      size_d  = size_q;
      sign_d  = sign_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      res_d   = res_q;

      w_busy     = (state_q == S_REQ) || (state_q == S_WAIT);
      // A flush during the flight cancels from that very cycle onwards.
      w_cancel   = cancel_q | (bus.flush & w_busy);
      w_complete = (state_q == S_WAIT) & bus.data_data_ok;

      case (state_q)
         S_IDLE: begin
            if (bus.mem_en && !bus.flush) begin
               wr_d    = bus.mem_wr;
               size_d  = bus.mem_size;
               sign_d  = bus.mem_sign;
               addr_d  = bus.mem_addr;
               wdata_d = bus.mem_wdata;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            if (bus.data_addr_ok) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (bus.data_data_ok) begin
               // A cancelled result is dropped; otherwise it is parked in
               // DONE only while the pipeline cannot consume it yet.
               if (!w_cancel && bus.pipe_hold) begin
                  res_d   = w_ext;
                  state_d = S_DONE;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: begin // S_DONE
            if (!bus.pipe_hold || bus.flush) begin
               state_d = S_IDLE;
            end
         end
      endcase

      // Cancel lives only as long as the transaction it belongs to.
      cancel_d = w_cancel & ((state_d == S_REQ) || (state_d == S_WAIT));
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         wr_q     <= 1'b0;
         size_q   <= 2'd0;
         sign_q   <= 1'b0;
         addr_q   <= 32'd0;
         wdata_q  <= 32'd0;
         res_q    <= 32'd0;
         cancel_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_q     <= wr_d;
         size_q   <= size_d;
         sign_q   <= sign_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         res_q    <= res_d;
         cancel_q <= cancel_d;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   logic w_data_ok;
   assign w_data_ok = w_complete & ~w_cancel;

   assign bus.data_ok_o   = w_data_ok;
   assign bus.mem_stall_o = ~w_cancel &
                            (((state_q == S_IDLE) & bus.mem_en & ~bus.flush) |
                             (state_q == S_REQ) |
                             ((state_q == S_WAIT) & ~bus.data_data_ok));
   assign bus.mem_rdata   = w_data_ok            ? w_ext :
                            (state_q == S_DONE)  ? res_q : 32'd0;

   assign bus.data_req    = (state_q == S_REQ);
   assign bus.data_wr     = wr_q;
   assign bus.data_size   = size_q;
   assign bus.data_addr   = addr_q;
   assign bus.data_wdata  = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_bridge
//  Description : Self-checking bench for dmem_bridge. Each transaction is
//                described by its bus timing (addr_ok delay, data_ok delay,
//                hold length, flush point); expected outputs follow from
//                those parameters and the load-extension arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_bridge;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   dmem_bridge_if bus ();

   dmem_bridge dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      bus.mem_en       = 1'b0;
      bus.mem_wr       = 1'b0;
      bus.mem_size     = 2'd0;
      bus.mem_sign     = 1'b0;
      bus.mem_addr     = 32'd0;
      bus.mem_wdata    = 32'd0;
      bus.flush        = 1'b0;
      bus.pipe_hold    = 1'b0;
      bus.data_addr_ok = 1'b0;
      bus.data_data_ok = 1'b0;
      bus.data_rdata   = 32'd0;
   endtask

   // Reference load extraction: shift the addressed lane down, mask, extend.
   function automatic logic [31:0] ext(input logic [1:0] sz, input logic sg,
                                       input logic [31:0] a, input logic [31:0] raw);
      logic [31:0] v;
      if (sz == 2'd0) begin
         v = (raw >> (8 * a[1:0])) & 32'h0000_00FF;
         if (sg && v[7]) v = v | 32'hFFFF_FF00;
      end else if (sz == 2'd1) begin
         v = (raw >> (16 * a[1])) & 32'h0000_FFFF;
         if (sg && v[15]) v = v | 32'hFFFF_0000;
      end else begin
         v = raw;
      end
      return v;
   endfunction

   // na: REQ cycles before addr_ok, nd: WAIT cycles before data_ok,
   // nh: cycles spent in DONE, flush_at: flight-cycle index of a one-cycle
   // flush (-1 none), fdone: flush on the first DONE cycle.
   task automatic run_txn(input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rd, input int na, input int nd,
                          input int nh, input int flush_at, input bit fdone);
      logic [31:0] exp;
      bit cx;
      bit last;
      int c;
      exp = ext(sz, sg, a, rd);
      cx  = 1'b0;
      // accept cycle
      quiet();
      bus.mem_en       = 1'b1;
      bus.mem_wr       = wr;
      bus.mem_size     = sz;
      bus.mem_sign     = sg;
      bus.mem_addr     = a;
      bus.mem_wdata    = wd;
      bus.pipe_hold    = 1'($urandom % 2);
      bus.data_data_ok = 1'($urandom % 2);
      #1;
      chk1("accept_stall", bus.mem_stall_o, 1'b1);
      chk1("accept_ok",    bus.data_ok_o,   1'b0);
      chk1("accept_req",   bus.data_req,    1'b0);
      tick();
      // REQ phase: other pipeline fields wiggle, latched bus fields must not
      for (int i = 0; i <= na; i++) begin
         c = i;
         bus.flush        = (c == flush_at);
         if (bus.flush) cx = 1'b1;
         bus.data_addr_ok = (i == na);
         bus.data_data_ok = 1'($urandom % 2);
         bus.mem_en       = 1'($urandom % 2);
         bus.mem_addr     = $urandom;
         bus.mem_wdata    = $urandom;
         bus.mem_wr       = 1'($urandom % 2);
         bus.mem_size     = 2'($urandom % 3);
         bus.pipe_hold    = 1'($urandom % 2);
         #1;
         chk1("req_req",   bus.data_req,    1'b1);
         chk ("req_addr",  bus.data_addr,   a);
         chk ("req_wdata", bus.data_wdata,  wd);
         chk1("req_wr",    bus.data_wr,     wr);
         chk ("req_size",  {30'd0, bus.data_size}, {30'd0, sz});
         chk1("req_stall", bus.mem_stall_o, !cx);
         chk1("req_ok",    bus.data_ok_o,   1'b0);
         tick();
      end
      // WAIT phase
      for (int j = 0; j <= nd; j++) begin
         c = na + 1 + j;
         last = (j == nd);
         bus.flush        = (c == flush_at);
         if (bus.flush) cx = 1'b1;
         bus.data_data_ok = last;
         bus.data_rdata   = last ? rd : $urandom;
         bus.pipe_hold    = last ? (nh > 0) : 1'($urandom % 2);
         bus.data_addr_ok = 1'($urandom % 2);
         bus.mem_en       = 1'($urandom % 2);
         #1;
         chk1("wait_req",   bus.data_req,    1'b0);
         chk1("wait_stall", bus.mem_stall_o, !cx && !last);
         chk1("wait_ok",    bus.data_ok_o,   last && !cx);
         if (last && !cx && !wr) chk("wait_rdata", bus.mem_rdata, exp);
         tick();
      end
      // DONE phase (only for a live result)
      if (!cx) begin
         for (int k = 0; k < nh; k++) begin
            quiet();
            bus.flush        = fdone && (k == 0);
            bus.pipe_hold    = (k < nh - 1) || bus.flush;
            bus.data_data_ok = 1'($urandom % 2);
            bus.data_rdata   = $urandom;
            #1;
            chk1("done_stall", bus.mem_stall_o, 1'b0);
            chk1("done_ok",    bus.data_ok_o,   1'b0);
            chk1("done_req",   bus.data_req,    1'b0);
            if (!wr) chk("done_rdata", bus.mem_rdata, exp);
            tick();
            if (fdone) break;
         end
      end
      // Back in IDLE; hold + stray data_ok would keep a wrong DONE alive,
      // which the next accept cycle then exposes.
      quiet();
      bus.pipe_hold    = 1'b1;
      bus.data_data_ok = 1'b1;
      #1;
      chk1("idle_req",   bus.data_req,    1'b0);
      chk1("idle_stall", bus.mem_stall_o, 1'b0);
      chk1("idle_ok",    bus.data_ok_o,   1'b0);
      tick();
   endtask

   initial begin
      logic        wr, sg;
      logic [1:0]  sz;
      logic [31:0] a;
      int          na, nd, nh, fa;
      bit          fd;

      quiet();
      rst = 1'b1;
      tick();
      tick();
      chk1("rst_req",   bus.data_req,    1'b0);
      chk1("rst_stall", bus.mem_stall_o, 1'b0);
      chk1("rst_ok",    bus.data_ok_o,   1'b0);
      chk ("rst_rdata", bus.mem_rdata,   32'd0);
      rst = 1'b0;
      tick();

      // word load, immediate handshakes
      run_txn(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'd0, 32'hDEAD_BEEF, 0, 0, 0, -1, 1'b0);
      // signed / unsigned byte load from the top lane
      run_txn(1'b0, 2'd0, 1'b1, 32'h0000_0103, 32'd0, 32'h8012_3456, 0, 1, 0, -1, 1'b0);
      run_txn(1'b0, 2'd0, 1'b0, 32'h0000_0103, 32'd0, 32'h8012_3456, 0, 1, 0, -1, 1'b0);
      // store, addr_ok delayed 4 cycles
      run_txn(1'b1, 2'd2, 1'b0, 32'h0000_0200, 32'hCAFE_F00D, 32'd0, 4, 1, 0, -1, 1'b0);
      // completion under a 3-cycle pipe_hold
      run_txn(1'b0, 2'd1, 1'b1, 32'h0000_0302, 32'd0, 32'h8001_7FFF, 0, 0, 3, -1, 1'b0);
      // flush in WAIT, flush in REQ, flush in DONE
      run_txn(1'b0, 2'd2, 1'b0, 32'h0000_0400, 32'd0, 32'h1234_5678, 0, 2, 2, 1, 1'b0);
      run_txn(1'b1, 2'd2, 1'b0, 32'h0000_0404, 32'h5555_AAAA, 32'd0, 2, 1, 0, 1, 1'b0);
      run_txn(1'b0, 2'd1, 1'b0, 32'h0000_0406, 32'd0, 32'hABCD_0123, 1, 0, 3, -1, 1'b1);

      // flush in IDLE: nothing accepted
      quiet();
      bus.mem_en = 1'b1;
      bus.flush  = 1'b1;
      #1;
      chk1("iflush_stall", bus.mem_stall_o, 1'b0);
      tick();
      quiet();
      #1;
      chk1("iflush_req", bus.data_req, 1'b0);
      tick();

      // reset while in REQ, then a stray data_ok
      quiet();
      bus.mem_en   = 1'b1;
      bus.mem_addr = 32'h0000_0500;
      tick();
      quiet();
      rst = 1'b1;
      #1;
      chk1("prerst_req", bus.data_req, 1'b1);
      tick();
      rst = 1'b0;
      #1;
      chk1("postrst_req",   bus.data_req,    1'b0);
      chk1("postrst_stall", bus.mem_stall_o, 1'b0);
      bus.data_data_ok = 1'b1;
      bus.data_rdata   = $urandom;
      #1;
      chk1("stray_ok",    bus.data_ok_o,   1'b0);
      chk ("stray_rdata", bus.mem_rdata,   32'd0);
      chk1("stray_stall", bus.mem_stall_o, 1'b0);
      tick();

      // randomized traffic
      for (int t = 0; t < 60; t++) begin
         wr = 1'($urandom % 2);
         sz = 2'($urandom % 3);
         sg = 1'($urandom % 2);
         a  = $urandom;
         if (sz == 2'd1) a[0] = 1'b0;
         if (sz == 2'd2) a[1:0] = 2'd0;
         na = int'($urandom % 5);
         nd = int'($urandom % 4);
         nh = int'($urandom % 4);
         fa = ($urandom % 4 == 0) ? int'($urandom % (na + nd + 2)) : -1;
         fd = ($urandom % 3 == 0);
         run_txn(wr, sz, sg, a, $urandom, $urandom, na, nd, nh, fa, fd);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
